// File: rtl/lcm_merge_pkg.sv
// rtl/lcm_merge_pkg.sv - shared word encodings, FSM states and widths for lcm_merge
package lcm_merge_pkg;

  localparam int WORD_W   = 134;
  localparam int VF_DEPTH = 16;

  typedef enum logic [1:0] {
    WT_HEAD = 2'b01,
    WT_MID  = 2'b11,
    WT_TAIL = 2'b10
  } word_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  function automatic logic is_tail(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2] == WT_TAIL;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy, full and empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign used    = count;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcm_merge.sv
// rtl/lcm_merge.sv - merges lcm beacon and user packet streams towards ESW
module lcm_merge
  import lcm_merge_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int RDY_THRESH = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [133:0]      in_lcm_data,
  input  logic              in_lcm_data_wr,
  input  logic              in_lcm_data_valid,
  input  logic              in_lcm_data_valid_wr,
  input  logic [133:0]      in_um_data,
  input  logic              in_um_data_wr,
  input  logic              in_um_data_valid,
  input  logic              in_um_data_valid_wr,
  output logic              out_lcm_ready,
  output logic              out_um_ready,
  input  logic              in_esw_alf,
  output logic [133:0]      out_data,
  output logic              out_data_wr,
  output logic              out_data_valid,
  output logic              out_data_valid_wr,
  output logic [31:0]       out_lcm_pkt_cnt,
  output logic [31:0]       out_um_pkt_cnt,
  output logic [31:0]       out_drop_cnt,
  output logic              out_ovf_err
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int VAW = $clog2(VF_DEPTH);
  localparam logic [DAW:0] RDY_LIM = (DAW+1)'(RDY_THRESH);
  localparam logic [VAW:0] VF_LIM  = (VAW+1)'(VF_DEPTH - 1);

  logic [WORD_W-1:0] lcm_d_dout, um_d_dout;
  logic [DAW:0]      lcm_d_used, um_d_used;
  logic              lcm_d_full, um_d_full, lcm_d_empty, um_d_empty;
  logic [0:0]        lcm_v_dout, um_v_dout;
  logic [VAW:0]      lcm_v_used, um_v_used;
  logic              lcm_v_full, um_v_full, lcm_v_empty, um_v_empty;

  state_e            state, state_nxt;
  logic              cur_um, last_um, hold;
  logic              sel_um, head_flag, take_grant, hold_set;
  logic              rd_data_en, pop_valid, src_empty;
  logic [WORD_W-1:0] src_word;

  logic              s1_vld, s1_um;
  logic [WORD_W-1:0] s1_word;
  logic              s1_tail;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_lcm_dfifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in_lcm_data_wr), .wr_data(in_lcm_data),
    .rd_en(rd_data_en & ~cur_um), .rd_data(lcm_d_dout), .used(lcm_d_used),
    .full(lcm_d_full), .empty(lcm_d_empty)
  );

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_um_dfifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in_um_data_wr), .wr_data(in_um_data),
    .rd_en(rd_data_en & cur_um), .rd_data(um_d_dout), .used(um_d_used),
    .full(um_d_full), .empty(um_d_empty)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(VF_DEPTH)) u_lcm_vfifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in_lcm_data_valid_wr), .wr_data(in_lcm_data_valid),
    .rd_en(pop_valid & ~cur_um), .rd_data(lcm_v_dout), .used(lcm_v_used),
    .full(lcm_v_full), .empty(lcm_v_empty)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(VF_DEPTH)) u_um_vfifo (
    .clk(clk), .rst_n(rst_n), .wr_en(in_um_data_valid_wr), .wr_data(in_um_data_valid),
    .rd_en(pop_valid & cur_um), .rd_data(um_v_dout), .used(um_v_used),
    .full(um_v_full), .empty(um_v_empty)
  );

  // A held grant (blocked by ESW almost-full) keeps its source until it is sent.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    hold_set   = 1'b0;
    rd_data_en = 1'b0;
    pop_valid  = 1'b0;
    if (hold)
      sel_um = cur_um;
    else if (!lcm_v_empty && !um_v_empty)
      sel_um = ~last_um;
    else
      sel_um = ~um_v_empty;
    head_flag = sel_um ? um_v_dout[0] : lcm_v_dout[0];
    src_empty = cur_um ? um_d_empty : lcm_d_empty;
    src_word  = cur_um ? um_d_dout : lcm_d_dout;

    case (state)
      ST_IDLE: begin
        if (hold || !lcm_v_empty || !um_v_empty) begin
          if (!head_flag) begin
            state_nxt  = ST_DROP;
            take_grant = 1'b1;
          end else if (!in_esw_alf) begin
            state_nxt  = ST_XFER;
            take_grant = 1'b1;
          end else begin
            hold_set = 1'b1;
          end
        end
      end
      ST_XFER, ST_DROP: begin
        if (!src_empty) begin
          rd_data_en = 1'b1;
          if (is_tail(src_word)) begin
            pop_valid = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cur_um  <= 1'b0;
      last_um <= 1'b1;
      hold    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        cur_um  <= sel_um;
        last_um <= sel_um;
        hold    <= 1'b0;
      end else if (hold_set) begin
        cur_um <= sel_um;
        hold   <= 1'b1;
      end
    end
  end

  assign s1_tail = is_tail(s1_word);

  // Two-stage output: FIFO pop into s1, then the registered ESW interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld            <= 1'b0;
      s1_um             <= 1'b0;
      s1_word           <= '0;
      out_data          <= '0;
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      out_lcm_pkt_cnt   <= '0;
      out_um_pkt_cnt    <= '0;
      out_drop_cnt      <= '0;
      out_ovf_err       <= 1'b0;
      out_lcm_ready     <= 1'b0;
      out_um_ready      <= 1'b0;
    end else begin
      s1_vld            <= rd_data_en && (state == ST_XFER);
      s1_um             <= cur_um;
      s1_word           <= src_word;
      out_data          <= s1_vld ? s1_word : '0;
      out_data_wr       <= s1_vld;
      out_data_valid    <= s1_vld & s1_tail;
      out_data_valid_wr <= s1_vld & s1_tail;
      if (s1_vld && s1_tail) begin
        if (s1_um) out_um_pkt_cnt  <= out_um_pkt_cnt + 32'd1;
        else       out_lcm_pkt_cnt <= out_lcm_pkt_cnt + 32'd1;
      end
      if (pop_valid && (state == ST_DROP)) out_drop_cnt <= out_drop_cnt + 32'd1;
      if ((in_lcm_data_wr && lcm_d_full) || (in_um_data_wr && um_d_full) ||
          (in_lcm_data_valid_wr && lcm_v_full) || (in_um_data_valid_wr && um_v_full))
        out_ovf_err <= 1'b1;
      out_lcm_ready <= (lcm_d_used <= RDY_LIM) && (lcm_v_used < VF_LIM);
      out_um_ready  <= (um_d_used <= RDY_LIM) && (um_v_used < VF_LIM);
    end
  end

endmodule

// File: tb/tb_lcm_merge.sv
// tb/tb_lcm_merge.sv - directed self-checking bench for lcm_merge
module tb_lcm_merge;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  logic         clk;
  logic         rst_n;
  logic [133:0] in_lcm_data, in_um_data;
  logic         in_lcm_data_wr, in_lcm_data_valid, in_lcm_data_valid_wr;
  logic         in_um_data_wr, in_um_data_valid, in_um_data_valid_wr;
  logic         out_lcm_ready, out_um_ready, in_esw_alf;
  logic [133:0] out_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic [31:0]  out_lcm_pkt_cnt, out_um_pkt_cnt, out_drop_cnt;
  logic         out_ovf_err;

  int total;
  int passed;
  logic [133:0] w [6];
  logic [133:0] u [3];

  lcm_merge dut (
    .clk(clk), .rst_n(rst_n),
    .in_lcm_data(in_lcm_data), .in_lcm_data_wr(in_lcm_data_wr),
    .in_lcm_data_valid(in_lcm_data_valid), .in_lcm_data_valid_wr(in_lcm_data_valid_wr),
    .in_um_data(in_um_data), .in_um_data_wr(in_um_data_wr),
    .in_um_data_valid(in_um_data_valid), .in_um_data_valid_wr(in_um_data_valid_wr),
    .out_lcm_ready(out_lcm_ready), .out_um_ready(out_um_ready), .in_esw_alf(in_esw_alf),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
    .out_lcm_pkt_cnt(out_lcm_pkt_cnt), .out_um_pkt_cnt(out_um_pkt_cnt),
    .out_drop_cnt(out_drop_cnt), .out_ovf_err(out_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [133:0] mk(input logic [1:0] t, input logic [31:0] id);
    return {t, 4'd8, 96'h0, id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_lcm_data_wr = 0; in_lcm_data_valid_wr = 0; in_lcm_data_valid = 0;
    in_um_data_wr = 0;  in_um_data_valid_wr = 0;  in_um_data_valid = 0;
    in_esw_alf = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_lcm(input logic [133:0] d);
    in_lcm_data = d; in_lcm_data_wr = 1'b1;
    step();
    in_lcm_data_wr = 1'b0;
  endtask

  task automatic lcm_valid(input logic v);
    in_lcm_data_valid = v; in_lcm_data_valid_wr = 1'b1;
    step();
    in_lcm_data_valid_wr = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0;
    in_lcm_data = '0; in_um_data = '0;
    rst_n = 1'b0;
    in_lcm_data_wr = 0; in_lcm_data_valid_wr = 0; in_lcm_data_valid = 0;
    in_um_data_wr = 0;  in_um_data_valid_wr = 0;  in_um_data_valid = 0;
    in_esw_alf = 0;
    step(); step();

    // reset state
    check("rst_wr", out_data_wr, 0);
    check("rst_lcm_rdy", out_lcm_ready, 0);
    check("rst_cnt", {out_lcm_pkt_cnt, out_um_pkt_cnt, out_drop_cnt}, 0);
    check("rst_ovf", out_ovf_err, 0);
    rst_n = 1'b1;
    step();
    check("rel_rdy", {out_lcm_ready, out_um_ready}, 2'b11);

    // LCM-only 4-word packet: words at N+3..N+6
    w[0] = mk(HEAD, 32'h10); w[1] = mk(MID, 32'h11);
    w[2] = mk(MID, 32'h12);  w[3] = mk(TAIL, 32'h13);
    for (int i = 0; i < 4; i++) push_lcm(w[i]);
    lcm_valid(1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t1_wr_%0d", k), out_data_wr, (k >= 3 && k <= 6));
      check($sformatf("t1_vwr_%0d", k), {out_data_valid_wr, out_data_valid}, (k == 6) ? 2'b11 : 2'b00);
      if (k >= 3 && k <= 6) check($sformatf("t1_data_%0d", k), out_data, w[k-3]);
    end
    check("t1_lcm_cnt", out_lcm_pkt_cnt, 1);
    check("t1_um_cnt", out_um_pkt_cnt, 0);

    // both inputs complete together: LCM first, one idle gap, then UM
    do_reset();
    w[0] = mk(HEAD, 32'h20); w[1] = mk(TAIL, 32'h21);
    u[0] = mk(HEAD, 32'h30); u[1] = mk(TAIL, 32'h31);
    for (int i = 0; i < 2; i++) begin
      in_lcm_data = w[i]; in_um_data = u[i];
      in_lcm_data_wr = 1; in_um_data_wr = 1;
      step();
    end
    in_lcm_data_wr = 0; in_um_data_wr = 0;
    in_lcm_data_valid = 1; in_um_data_valid = 1;
    in_lcm_data_valid_wr = 1; in_um_data_valid_wr = 1;
    step();
    in_lcm_data_valid_wr = 0; in_um_data_valid_wr = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t2_wr_%0d", k), out_data_wr, (k == 3 || k == 4 || k == 6 || k == 7));
      if (k == 3) check("t2_l0", out_data, w[0]);
      if (k == 4) check("t2_l1", out_data, w[1]);
      if (k == 6) check("t2_u0", out_data, u[0]);
      if (k == 7) check("t2_u1", out_data, u[1]);
    end
    check("t2_cnts", {out_lcm_pkt_cnt, out_um_pkt_cnt}, {32'd1, 32'd1});

    // UM 3-word packet with valid=0 is dropped silently
    do_reset();
    u[0] = mk(HEAD, 32'h40); u[1] = mk(MID, 32'h41); u[2] = mk(TAIL, 32'h42);
    for (int i = 0; i < 3; i++) begin
      in_um_data = u[i]; in_um_data_wr = 1;
      step();
    end
    in_um_data_wr = 0; in_um_data_valid = 0; in_um_data_valid_wr = 1;
    step();
    in_um_data_valid_wr = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t3_wr_%0d", k), out_data_wr, 0);
    end
    check("t3_drop", out_drop_cnt, 1);
    check("t3_um_cnt", out_um_pkt_cnt, 0);

    // ESW almost-full holds a pending packet; raising it mid-packet does not cut it
    do_reset();
    in_esw_alf = 1;
    w[0] = mk(HEAD, 32'h50); w[1] = mk(MID, 32'h51);
    w[2] = mk(MID, 32'h52);  w[3] = mk(TAIL, 32'h53);
    for (int i = 0; i < 4; i++) push_lcm(w[i]);
    lcm_valid(1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t4_hold_%0d", k), out_data_wr, 0);
    end
    in_esw_alf = 0;
    step();
    check("t4_m0", out_data_wr, 0);
    step();
    check("t4_m1", out_data_wr, 0);
    for (int k = 2; k <= 5; k++) begin
      step();
      in_esw_alf = 1;
      check($sformatf("t4_wr_%0d", k), out_data_wr, 1);
      check($sformatf("t4_data_%0d", k), out_data, w[k-2]);
    end
    check("t4_valid_tail", out_data_valid_wr, 1);
    check("t4_cnt", out_lcm_pkt_cnt, 1);
    in_esw_alf = 0;

    // UM fill: ready threshold at 160/161, overflow on the 257th word
    do_reset();
    for (int i = 0; i < 160; i++) begin
      in_um_data = mk(MID, i); in_um_data_wr = 1;
      step();
    end
    in_um_data_wr = 0;
    step();
    check("t5_rdy160", out_um_ready, 1);
    in_um_data = mk(MID, 32'd160); in_um_data_wr = 1;
    step();
    in_um_data_wr = 0;
    step();
    check("t5_rdy161", out_um_ready, 0);
    check("t5_lcm_rdy", out_lcm_ready, 1);
    for (int i = 161; i < 256; i++) begin
      in_um_data = mk(MID, i); in_um_data_wr = 1;
      step();
    end
    check("t5_ovf256", out_ovf_err, 0);
    step();
    in_um_data_wr = 0;
    check("t5_ovf257", out_ovf_err, 1);
    step();
    check("t5_ovf_sticky", out_ovf_err, 1);

    // reset mid-XFER at word 2 of 5, then a fresh packet with no stale words
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = mk((i == 0) ? HEAD : (i == 4) ? TAIL : MID, 32'h60 + i);
    for (int i = 0; i < 5; i++) push_lcm(w[i]);
    lcm_valid(1'b1);
    for (int k = 1; k <= 4; k++) step();
    check("t6_word2", out_data, w[1]);
    rst_n = 1'b0;
    #1;
    check("t6_async_wr", out_data_wr, 0);
    check("t6_async_data", out_data, 0);
    check("t6_async_rdy", out_lcm_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t6_stale_%0d", k), out_data_wr, 0);
    end
    check("t6_rdy", out_lcm_ready, 1);
    w[0] = mk(HEAD, 32'h70); w[1] = mk(TAIL, 32'h71);
    push_lcm(w[0]);
    push_lcm(w[1]);
    lcm_valid(1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("t6_new_wr_%0d", k), out_data_wr, (k == 3 || k == 4));
      if (k == 3 || k == 4) check($sformatf("t6_new_d_%0d", k), out_data, w[k-3]);
    end
    check("t6_cnt", out_lcm_pkt_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcm_merge.md
LCM_MERGE -- requirements
Module: lcm_merge

Interface
REQ-001 Parameter: DATA_DEPTH, 256, words per input data FIFO (134-bit words).
REQ-002 Parameter: RDY_THRESH, 160, max data FIFO occupancy at which the input ready flag stays high.
REQ-003 Ports are listed as: name, direction, width, meaning.
REQ-004 clk  in  1  single clock for the whole block.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 in_lcm_data / in_lcm_data_wr / in_lcm_data_valid / in_lcm_data_valid_wr  in  134/1/1/1  beacon report stream from lcm.
REQ-007 in_um_data / in_um_data_wr / in_um_data_valid / in_um_data_valid_wr  in  134/1/1/1  user-pipeline packet stream.
REQ-008 out_lcm_ready, out_um_ready  out  1 each  per-input space flag; high means the source may start a new packet.
REQ-009 in_esw_alf  in  1  ESW almost-full; high blocks the start of a new forwarded packet.
REQ-010 out_data / out_data_wr / out_data_valid / out_data_valid_wr  out  134/1/1/1  merged stream to ESW.
REQ-011 out_lcm_pkt_cnt, out_um_pkt_cnt, out_drop_cnt  out  32 each  forwarded-packet and dropped-packet counters.
REQ-012 out_ovf_err  out  1  sticky flag, set on a write to a full FIFO.

Function
REQ-013 Word format: [133:132] = 01 head, 11 middle, 10 tail; [131:128] = valid bytes in word; [127:0] = payload.
REQ-014 Each input writes its word into its own data FIFO when *_data_wr=1.
REQ-015 Each input writes *_data_valid into a 16-entry, 1-bit valid FIFO when *_data_valid_wr=1, which marks the end of the packet.
REQ-016 out_*_ready = (data FIFO used <= RDY_THRESH) AND (valid FIFO used < 15), registered.
REQ-017 FSM states: IDLE, XFER, DROP.
REQ-018 In IDLE, an input is eligible when its valid FIFO is non-empty.
REQ-019 In IDLE, a single eligible input is granted.
REQ-020 In IDLE with both inputs eligible, the input not granted last is granted; after reset the last-grant pointer = UM, so LCM wins first.
REQ-021 On grant with head valid flag = 1: go to XFER if in_esw_alf=0; otherwise stay in IDLE with the grant held (no re-arbitration until sent).
REQ-022 On grant with head valid flag = 0: go to DROP regardless of in_esw_alf.
REQ-023 XFER: one data FIFO read per cycle; the read word appears on out_data with out_data_wr=1 exactly 1 cycle later; no gaps.
REQ-024 XFER, tail word output cycle: out_data_valid=1 and out_data_valid_wr=1; pop the valid FIFO; increment the granted input's pkt counter; return to IDLE.
REQ-025 DROP: read words until tail with out_data_wr=0; pop the valid FIFO; increment out_drop_cnt; return to IDLE.
REQ-026 Latency: valid_wr sampled at cycle N with the block idle and alf=0 gives the first out_data_wr at cycle N+3.
REQ-027 Back-to-back packets: at least 1 IDLE cycle between a tail and the next head.
REQ-028 in_esw_alf is checked only in IDLE; a packet in flight always completes.
REQ-029 A write to a full data FIFO or full valid FIFO is discarded and sets out_ovf_err.
REQ-030 Counters wrap modulo 2^32.
REQ-031 Simultaneous write and read on the same FIFO in one cycle keeps the occupancy unchanged.

Reset
REQ-032 Reset asserted at any time, including mid-packet: FIFOs emptied, FSM to IDLE, last-grant = UM, all outputs 0.
REQ-033 All counters and out_ovf_err reset to 0; out_*_ready go high on the first cycle after release.

Structure
REQ-034 Shared package holds: word-type encodings (HEAD/MID/TAIL), FSM state encoding, 134-bit word width constant.
REQ-035 One sub-module sync_fifo (parameterised width/depth, with used-count, full and empty outputs), instantiated four times.

Verification
REQ-036 LCM-only 4-word packet, valid=1 -> 4 out words at N+3..N+6; valid strobe on the tail word; out_lcm_pkt_cnt=1.
REQ-037 Both inputs complete a 2-word packet in the same cycle -> LCM packet first, then UM packet; each counter=1.
REQ-038 UM 3-word packet with valid=0 -> no out_data_wr; out_drop_cnt=1; out_um_pkt_cnt=0.
REQ-039 in_esw_alf=1 while an LCM packet is pending -> no output; deassert -> packet starts 1 cycle later. alf=1 mid-packet -> packet completes.
REQ-040 Write 161 words to UM without reads -> out_um_ready=0; 257th word -> out_ovf_err=1.
REQ-041 rst_n low mid-XFER at word 2 of 5 -> outputs 0 at once; after release, FIFOs empty, no stale words emitted.
